// File: rtl/iob_aoi_pipe.sv
// iob_aoi_pipe: pipelined, parametrised AND-OR-INVERT / OR-AND-INVERT array.
//
// Evaluates N_AND terms of M inputs each, bitwise over W-bit operands:
//   mode 0 (AOI): y = ~( OR_t ( AND_k x[t][k] ) )
//   mode 1 (OAI): y = ~( AND_t ( OR_k x[t][k] ) )
// Stage 1 registers the first-level terms plus mode. Stage 2 registers the
// combined, inverted result. A valid/ready handshake gives full backpressure.
//
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset (flushes both stages)
//   cke_i    clock enable; 0 holds every register and blocks transfers
//   data_i   packed operands, term t input k at [(t*M+k)*W +: W]
//   mode_i   0 = AOI, 1 = OAI, travels with its transfer
//   valid_i  input transfer valid
//   ready_o  block can accept input
//   data_o   registered result
//   valid_o  result valid
//   ready_i  downstream accepts result
module iob_aoi_pipe #(
  parameter int W     = 1,
  parameter int N_AND = 2,
  parameter int M     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cke_i,
  input  logic [N_AND*M*W-1:0] data_i,
  input  logic                 mode_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [W-1:0]         data_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int NT = N_AND * W;

  logic [NT-1:0] term_c;
  logic [NT-1:0] term_q;
  logic          mode_q;
  logic          v1;
  logic [W-1:0]  res_c;
  logic [W-1:0]  data_q;
  logic          v2;
  logic          ready1;
  logic          ready2;
  logic          comb_bit;

  // First-level terms, bit (t*W + j). The starting value is the identity of
  // the reduction: 1 for the AND used in AOI, 0 for the OR used in OAI.
  always_comb begin
    term_c = '0;
    for (int t = 0; t < N_AND; t++) begin
      for (int j = 0; j < W; j++) begin
        term_c[t*W+j] = ~mode_i;
        for (int k = 0; k < M; k++) begin
          if (mode_i)
            term_c[t*W+j] = term_c[t*W+j] | data_i[(t*M+k)*W+j];
          else
            term_c[t*W+j] = term_c[t*W+j] & data_i[(t*M+k)*W+j];
        end
      end
    end
  end

  // Second level uses the mode that was captured with the terms, so mixed
  // AOI/OAI streams stay correct back-to-back.
  always_comb begin
    res_c    = '0;
    comb_bit = 1'b0;
    for (int j = 0; j < W; j++) begin
      comb_bit = mode_q;
      for (int t = 0; t < N_AND; t++) begin
        if (mode_q)
          comb_bit = comb_bit & term_q[t*W+j];
        else
          comb_bit = comb_bit | term_q[t*W+j];
      end
      res_c[j] = ~comb_bit;
    end
  end

  assign ready2  = ~v2 | ready_i;
  assign ready1  = ~v1 | ready2;
  assign ready_o = cke_i & ready1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      term_q <= '0;
      mode_q <= 1'b0;
      v1     <= 1'b0;
      data_q <= '0;
      v2     <= 1'b0;
    end else if (cke_i) begin
      if (ready2) begin
        v2 <= v1;
        // Only overwrite the result when real data moves in, so data_o
        // keeps its last value while the output is idle.
        if (v1)
          data_q <= res_c;
      end
      if (ready1) begin
        v1 <= valid_i;
        if (valid_i) begin
          term_q <= term_c;
          mode_q <= mode_i;
        end
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = v2;

endmodule

// File: tb/tb_iob_aoi_pipe.sv
module tb_iob_aoi_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cke = 1'b1;

  // Instance A: W=1, N_AND=2, M=2
  logic [3:0] a_data  = '0;
  logic       a_mode  = 1'b0;
  logic       a_valid = 1'b0;
  logic       a_rdy;
  logic [0:0] a_dout;
  logic       a_vout;
  logic       a_ack   = 1'b1;

  // Instance B: W=4, N_AND=3, M=3
  logic [35:0] b_data  = '0;
  logic        b_mode  = 1'b0;
  logic        b_valid = 1'b0;
  logic        b_rdy;
  logic [3:0]  b_dout;
  logic        b_vout;
  logic        b_ack   = 1'b1;

  int total = 0;
  int bad   = 0;
  int a_outs = 0;
  int b_outs = 0;
  int n;
  int outs0;
  logic [0:0] frozen;

  logic       qa[$];
  logic [3:0] qb[$];

  // Hand-derived truth tables, index = {d,c,b,a}
  logic [15:0] aoi_tbl = 16'h0777;
  logic [15:0] oai_tbl = 16'h111F;
  logic [3:0]  bp[4]   = '{4'd0, 4'd3, 4'd12, 4'd5};

  always #5 clk = ~clk;

  iob_aoi_pipe #(.W(1), .N_AND(2), .M(2)) u_a (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .data_i(a_data), .mode_i(a_mode),
    .valid_i(a_valid), .ready_o(a_rdy), .data_o(a_dout), .valid_o(a_vout),
    .ready_i(a_ack)
  );

  iob_aoi_pipe #(.W(4), .N_AND(3), .M(3)) u_b (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .data_i(b_data), .mode_i(b_mode),
    .valid_i(b_valid), .ready_o(b_rdy), .data_o(b_dout), .valid_o(b_vout),
    .ready_i(b_ack)
  );

  function automatic logic model_a(logic [3:0] x, logic m);
    return m ? oai_tbl[x] : aoi_tbl[x];
  endfunction

  // AOI output bit is 0 iff some term has all inputs high;
  // OAI output bit is 1 iff some term has all inputs low.
  function automatic logic [3:0] model_b(logic [35:0] x, logic m);
    logic [3:0] y;
    logic all1, all0;
    for (int j = 0; j < 4; j++) begin
      y[j] = ~m;
      for (int t = 0; t < 3; t++) begin
        all1 = 1'b1;
        all0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
          if (x[(t*3+k)*4+j]) all0 = 1'b0;
          else                all1 = 1'b0;
        end
        if (!m && all1) y[j] = 1'b0;
        if (m && all0)  y[j] = 1'b1;
      end
    end
    return y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with scoreboard bookkeeping for both instances.
  task automatic tick();
    logic acc_a, con_a, acc_b, con_b;
    #1;
    acc_a = a_valid & a_rdy & ~rst;
    con_a = a_vout & a_ack & cke & ~rst;
    acc_b = b_valid & b_rdy & ~rst;
    con_b = b_vout & b_ack & cke & ~rst;
    if (con_a) begin
      a_outs++;
      chk("a_out_expected", 64'(qa.size() > 0), 1);
      if (qa.size() > 0) chk("a_order", a_dout, qa.pop_front());
    end
    if (acc_a) qa.push_back(model_a(a_data, a_mode));
    if (con_b) begin
      b_outs++;
      chk("b_out_expected", 64'(qb.size() > 0), 1);
      if (qb.size() > 0) chk("b_result", b_dout, qb.pop_front());
    end
    if (acc_b) qb.push_back(model_b(b_data, b_mode));
    @(posedge clk);
    #1;
    if (rst) begin
      qa.delete();
      qb.delete();
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_valid", a_vout, 0);
    chk("rst_data", a_dout, 0);
    chk("rst_ready", a_rdy, 1);
    chk("rst_b_valid", b_vout, 0);
    chk("rst_b_data", b_dout, 0);
    cke = 1'b0;
    #1;
    chk("rst_ready_cke0", a_rdy, 0);
    cke = 1'b1;
    rst = 1'b0;

    // AOI sweep, first transfer right after reset, 2-cycle latency
    for (int i = 0; i < 16; i++) begin
      a_data = 4'(i); a_mode = 1'b0; a_valid = 1'b1;
      tick();
      if (i == 0) chk("aoi_lat_empty", a_vout, 0);
      else begin
        chk("aoi_lat_v", a_vout, 1);
        chk("aoi_lat_d", a_dout, aoi_tbl[i-1]);
      end
    end
    a_valid = 1'b0;
    tick(); tick();
    chk("aoi_drain", qa.size(), 0);

    // OAI sweep
    for (int i = 0; i < 16; i++) begin
      a_data = 4'(i); a_mode = 1'b1; a_valid = 1'b1;
      tick();
      if (i > 0) chk("oai_lat_d", a_dout, oai_tbl[i-1]);
    end
    a_valid = 1'b0;
    tick(); tick();
    chk("oai_drain", qa.size(), 0);

    // Mixed modes back-to-back
    for (int i = 0; i < 16; i++) begin
      a_data = 4'(i); a_mode = i[0]; a_valid = 1'b1;
      tick();
    end
    a_valid = 1'b0; a_mode = 1'b0;
    tick(); tick();
    chk("mix_drain", qa.size(), 0);

    // Backpressure: 5 stalled cycles then release
    a_ack = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      a_valid = (n < 4);
      a_data  = bp[n];
      #1;
      if (a_valid && a_rdy) n++;
      tick();
      if (c >= 1) begin
        chk("bp_valid_hold", a_vout, 1);
        chk("bp_data_hold", a_dout, 1);
      end
    end
    chk("bp_accepts", n, 2);
    chk("bp_ready_low", a_rdy, 0);
    a_ack = 1'b1;
    outs0 = a_outs;
    for (int c = 0; c < 20; c++) begin
      a_valid = (n < 4);
      if (n < 4) a_data = bp[n];
      #1;
      if (a_valid && a_rdy) n++;
      tick();
    end
    chk("bp_delivered", a_outs - outs0, 4);
    chk("bp_drain", qa.size(), 0);

    // Reset with two transfers in flight
    a_valid = 1'b1; a_data = 4'd0;
    tick();
    a_data = 4'd1;
    tick();
    a_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("flush_valid", a_vout, 0);
    chk("flush_data", a_dout, 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("flush_no_ghost", a_vout, 0);
    end
    a_valid = 1'b1; a_data = 4'd4;
    tick();
    chk("post_rst_lat1", a_vout, 0);
    a_valid = 1'b0;
    tick();
    chk("post_rst_v", a_vout, 1);
    chk("post_rst_d", a_dout, 1);
    tick();

    // Clock enable low with valid and ready held high
    a_valid = 1'b1; a_data = 4'd0;
    tick();
    a_data = 4'd7;
    tick();
    frozen = a_dout;
    cke = 1'b0;
    a_data = 4'd15;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("cke_ready", a_rdy, 0);
      tick();
      chk("cke_valid", a_vout, 1);
      chk("cke_data", a_dout, frozen);
    end
    chk("cke_frozen_val", frozen, 1);
    cke = 1'b1;
    a_valid = 1'b0;
    outs0 = a_outs;
    tick(); tick(); tick();
    chk("cke_resume_outs", a_outs - outs0, 2);
    chk("cke_drain", qa.size(), 0);

    // Wide instance: alternating modes, random data and backpressure
    b_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      b_mode = c[0];
      b_data = 36'({$urandom(), $urandom()});
      b_ack  = 1'($urandom_range(0, 1));
      tick();
    end
    b_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      b_mode = ~b_mode;
      b_data = 36'({$urandom(), $urandom()});
      tick();
    end
    outs0 = b_outs;
    for (int c = 0; c < 10; c++) begin
      b_mode = ~b_mode;
      b_data = 36'({$urandom(), $urandom()});
      tick();
    end
    chk("b_throughput", b_outs - outs0, 10);
    b_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("b_drain", qb.size(), 0);
    chk("b_outs_seen", 64'(b_outs > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
